apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
Synthesizable APB4 master that converts a valid/ready command stream into APB transfers and returns a valid/ready response. It is the parametrised successor to the team's APB master BFM.
- Adds address decode across NUM_SLV slaves, per-slave PREADY/PRDATA/PSLVERR muxing, PSTRB, and a decode-error path.
- Sits between an internal bus master (CPU wrapper, DMA, or test sequencer) and the peripheral APB segment.

Parameters:
ADR_W, 32, address width (must be ≥ SLV_AW + SEL_W, where SEL_W = max(1, clog2(NUM_SLV))).
DAT_W, 32, data width, multiple of 8.
NUM_SLV, 4, number of slaves / PSEL lines, 1..16.
SLV_AW, 12, log2 of the byte size of each slave window.
TO_CYC, 16, wait-state limit before timeout abort (used only with the optional feature).

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADR_W  byte address
cmd_wdata  in  DAT_W  write data
cmd_strb  in  DAT_W/8  byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DAT_W  read data (0 for writes and errors)
rsp_err  out  1  PSLVERR, decode error, or timeout
PADDR  out  ADR_W  APB address
PSEL  out  NUM_SLV  one-hot slave select
PENABLE  out  1  access phase
PWRITE  out  1  direction
PWDATA  out  DAT_W  write data
PSTRB  out  DAT_W/8  write strobes
PREADY  in  NUM_SLV  per-slave ready
PRDATA  in  NUM_SLV*DAT_W  per-slave read data, slave i at [i*DAT_W +: DAT_W]
PSLVERR  in  NUM_SLV  per-slave error

Behaviour:
- Clocking and reset:
  - Single clock PCLK; reset PRESET is asynchronous, active-high.
  - On reset, all outputs go to 0: cmd_ready, rsp_valid, rsp_err, rsp_rdata, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB. The FSM returns to IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: cmd_ready=1. On cmd_valid, latch the command.
    - Decode hit: go to SETUP.
    - Decode miss: go to RESP with rsp_err=1 and rsp_rdata=0. No PSEL is asserted.
  - SETUP: PSEL[idx]=1, PENABLE=0. Always go to ACCESS next cycle.
  - ACCESS: PSEL[idx]=1, PENABLE=1.
    - While PREADY[idx]=0, stay in ACCESS.
    - On PREADY[idx]=1: capture PRDATA[idx] (reads only; 0 for writes) and PSLVERR[idx] into rsp_rdata/rsp_err, then go to RESP.
  - RESP: rsp_valid=1; hold rsp_rdata and rsp_err stable. Go to IDLE on rsp_ready.
- cmd_ready is 1 only in IDLE. Back-to-back commands therefore carry one IDLE bubble.
- Decode:
  - idx = cmd_addr[SLV_AW +: SEL_W].
  - Hit requires idx < NUM_SLV and cmd_addr[ADR_W-1 : SLV_AW+SEL_W] == 0.
- Latency with zero wait states: accept at cycle N → SETUP at N+1 → ACCESS at N+2 → rsp_valid at N+3.
- APB output rules:
  - PADDR, PWRITE, PWDATA and PSTRB are registered at accept and held stable through SETUP and ACCESS. They retain their last value in IDLE and RESP.
  - For reads, PSTRB=0 (APB4 rule).
- Only the selected slave's PREADY/PSLVERR are observed. Other slaves' PREADY toggling has no effect.
- Reset asserted mid-transfer: the transfer is dropped and no response is produced. After release, the block is in IDLE with cmd_ready=1 on the first clock.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - A wait counter clears on entering ACCESS and increments each ACCESS cycle with PREADY[idx]=0.
  - When the counter reaches TO_CYC, the transfer is aborted: PSEL and PENABLE drop, the FSM goes to RESP with rsp_err=1 and rsp_rdata=0.
  - PREADY arriving in the same cycle as the limit takes priority (normal completion).
- Not defined: no counter is implemented; ACCESS waits indefinitely.

Test Plan:
1. Write cmd_addr=0x0000_1004, wdata=0xDEADBEEF, strb=0xF, PREADY[1]=1 → PSEL=4'b0010 at N+1, PENABLE at N+2, PSTRB=0xF, rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
2. Read 0x0000_3010 with PREADY[3] low for 3 ACCESS cycles and PRDATA slice 3=0x1234_5678 → ACCESS lasts 4 cycles, PSTRB=0, rsp_rdata=0x1234_5678, PADDR stable throughout.
3. Command to 0x0001_0000 → PSEL stays 0, rsp_valid at N+1 with rsp_err=1, rsp_rdata=0.
4. Read slave 0 with PSLVERR[0]=1 on the PREADY cycle, rsp_ready held low for 5 cycles → rsp_err=1, rsp_valid and data held 5 cycles, cmd_ready=0 until the handshake completes.
5. Assert PRESET during ACCESS of a write to slave 2 → all outputs 0 immediately (asynchronously), no rsp_valid, cmd_ready=1 on the first clock after release.
6. With APB_TIMEOUT_EN and TO_CYC=16, PREADY[2] held low → abort after 16 wait cycles with rsp_err=1. Repeat with PREADY rising on the 16th cycle → normal completion with rsp_err=0.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB4 master: valid/ready command -> decoded APB transfer -> valid/ready response; 3 cycles accept-to-rsp_valid at zero wait states.
// Backpressure: cmd_ready only in IDLE, response held until rsp_ready; `define APB_TIMEOUT_EN aborts after TO_CYC wait states.
module apb_master_bridge #(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_AW  = 12,
  parameter int TO_CYC  = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADR_W-1:0]           cmd_addr,
  input  logic [DAT_W-1:0]           cmd_wdata,
  input  logic [DAT_W/8-1:0]         cmd_strb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DAT_W-1:0]           rsp_rdata,
  output logic                       rsp_err,
  output logic [ADR_W-1:0]           PADDR,
  output logic [NUM_SLV-1:0]         PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [DAT_W-1:0]           PWDATA,
  output logic [DAT_W/8-1:0]         PSTRB,
  input  logic [NUM_SLV-1:0]         PREADY,
  input  logic [NUM_SLV*DAT_W-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]         PSLVERR
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  generate
    if (ADR_W < SLV_AW + SEL_W || DAT_W % 8 != 0 || NUM_SLV < 1 || NUM_SLV > 16 || TO_CYC < 1) begin : g_bad_cfg
      $error("apb_master_bridge: illegal parameter combination");
    end
  endgenerate

  logic [1:0]           r_state;
  logic [SEL_W-1:0]     r_idx;
  logic                 r_cmd_ready;
  logic                 r_rsp_valid;
  logic                 r_rsp_err;
  logic [DAT_W-1:0]     r_rsp_rdata;
  logic [ADR_W-1:0]     r_paddr;
  logic [NUM_SLV-1:0]   r_psel;
  logic                 r_penable;
  logic                 r_pwrite;
  logic [DAT_W-1:0]     r_pwdata;
  logic [DAT_W/8-1:0]   r_pstrb;

  logic [SEL_W-1:0]     w_idx;
  logic [ADR_W-1:0]     w_upper;
  logic                 w_hit;
  logic                 w_pready;
  logic                 w_pslverr;
  logic [DAT_W-1:0]     w_prdata;
  logic                 w_timeout;

  assign w_idx     = cmd_addr[SLV_AW +: SEL_W];
  assign w_upper   = cmd_addr >> (SLV_AW + SEL_W);
  assign w_hit     = (w_upper == '0) && (32'(w_idx) < NUM_SLV);
  // Only the latched slave's handshake signals are ever looked at.
  assign w_pready  = PREADY[r_idx];
  assign w_pslverr = PSLVERR[r_idx];
  assign w_prdata  = PRDATA[r_idx*DAT_W +: DAT_W];

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_CYC + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  // The TO_CYC-th consecutive wait cycle aborts; PREADY in that cycle still wins.
  assign w_timeout = (r_wait_cnt == CNT_W'(TO_CYC - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_ACCESS && !w_pready) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_paddr     <= '0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_idx       <= w_idx;
            r_paddr     <= cmd_addr;
            r_pwrite    <= cmd_write;
            r_pwdata    <= cmd_wdata;
            r_pstrb     <= cmd_write ? cmd_strb : '0;
            if (w_hit) begin
              r_psel  <= NUM_SLV'(1) << w_idx;
              r_state <= S_SETUP;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_state     <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_pready) begin
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_pslverr;
            r_rsp_rdata <= r_pwrite ? '0 : w_prdata;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign PADDR     = r_paddr;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed cases plus random commands against a transaction-level model.
module tb_apb_master_bridge;
  localparam int ADR_W   = 32;
  localparam int DAT_W   = 32;
  localparam int NUM_SLV = 4;
  localparam int SLV_AW  = 12;
  localparam int TO_CYC  = 16;

  logic                     PCLK = 1'b0;
  logic                     PRESET;
  logic                     cmd_valid, cmd_ready, cmd_write;
  logic [ADR_W-1:0]         cmd_addr;
  logic [DAT_W-1:0]         cmd_wdata;
  logic [DAT_W/8-1:0]       cmd_strb;
  logic                     rsp_valid, rsp_ready, rsp_err;
  logic [DAT_W-1:0]         rsp_rdata;
  logic [ADR_W-1:0]         PADDR;
  logic [NUM_SLV-1:0]       PSEL;
  logic                     PENABLE, PWRITE;
  logic [DAT_W-1:0]         PWDATA;
  logic [DAT_W/8-1:0]       PSTRB;
  logic [NUM_SLV-1:0]       PREADY;
  logic [NUM_SLV*DAT_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]       PSLVERR;

  int n_chk = 0;
  int n_bad = 0;

  apb_master_bridge #(
    .ADR_W(ADR_W), .DAT_W(DAT_W), .NUM_SLV(NUM_SLV), .SLV_AW(SLV_AW), .TO_CYC(TO_CYC)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Randomize every slave except 'keep' so unselected slaves toggle freely.
  task automatic noise(input int keep);
    for (int i = 0; i < NUM_SLV; i++) begin
      if (i != keep) begin
        PREADY[i]               = 1'($urandom);
        PSLVERR[i]              = 1'($urandom);
        PRDATA[i*DAT_W +: DAT_W] = $urandom;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_cmd_ready"}, 64'(cmd_ready), 0);
    check_val({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    check_val({tag, "_rsp_err"},   64'(rsp_err),   0);
    check_val({tag, "_rsp_rdata"}, 64'(rsp_rdata), 0);
    check_val({tag, "_paddr"},     64'(PADDR),     0);
    check_val({tag, "_psel"},      64'(PSEL),      0);
    check_val({tag, "_penable"},   64'(PENABLE),   0);
    check_val({tag, "_pwrite"},    64'(PWRITE),    0);
    check_val({tag, "_pwdata"},    64'(PWDATA),    0);
    check_val({tag, "_pstrb"},     64'(PSTRB),     0);
  endtask

  // One complete command: model computes decode, response and cycle-by-cycle bus expectations.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, input int waits, input bit serr,
                     input logic [31:0] sdata, input int rdly);
    int         idx;
    bit         hit, abort;
    bit         exp_err;
    logic [31:0] exp_rdata;
    int         n_acc;
    idx   = int'((addr >> SLV_AW) % 4);
    hit   = (addr >> (SLV_AW + 2)) == 0;
    abort = 1'b0;
`ifdef APB_TIMEOUT_EN
    abort = hit && (waits >= TO_CYC);
`endif
    exp_err   = !hit || abort || serr;
    exp_rdata = (!hit || abort || wr) ? 32'h0 : sdata;

    @(negedge PCLK);
    check_val("cmd_ready_idle", 64'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
    noise(idx);
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom;
    cmd_wdata = $urandom; cmd_strb = 4'($urandom);

    if (hit) begin
      @(negedge PCLK);
      check_val("setup_psel",    64'(PSEL),    64'(1) << idx);
      check_val("setup_penable", 64'(PENABLE), 0);
      check_val("setup_paddr",   64'(PADDR),   64'(addr));
      check_val("setup_pwrite",  64'(PWRITE),  64'(wr));
      check_val("setup_pwdata",  64'(PWDATA),  64'(wd));
      check_val("setup_pstrb",   64'(PSTRB),   wr ? 64'(st) : 64'h0);
      check_val("setup_rsp_vld", 64'(rsp_valid), 0);
      check_val("setup_cmd_rdy", 64'(cmd_ready), 0);
      noise(idx);
      PREADY[idx] = 1'($urandom);
      n_acc = abort ? TO_CYC : waits + 1;
      for (int k = 0; k < n_acc; k++) begin
        @(negedge PCLK);
        check_val("acc_psel",    64'(PSEL),    64'(1) << idx);
        check_val("acc_penable", 64'(PENABLE), 1);
        check_val("acc_paddr",   64'(PADDR),   64'(addr));
        check_val("acc_pstrb",   64'(PSTRB),   wr ? 64'(st) : 64'h0);
        check_val("acc_rsp_vld", 64'(rsp_valid), 0);
        noise(idx);
        PREADY[idx]                = !abort && (k == waits);
        PSLVERR[idx]               = (k == waits) ? serr : 1'($urandom);
        PRDATA[idx*DAT_W +: DAT_W] = (k == waits) ? sdata : $urandom;
      end
    end

    for (int d = 0; d <= rdly; d++) begin
      @(negedge PCLK);
      check_val("rsp_valid",   64'(rsp_valid), 1);
      check_val("rsp_err",     64'(rsp_err),   64'(exp_err));
      check_val("rsp_rdata",   64'(rsp_rdata), 64'(exp_rdata));
      check_val("rsp_cmd_rdy", 64'(cmd_ready), 0);
      check_val("rsp_psel",    64'(PSEL),      0);
      check_val("rsp_penable", 64'(PENABLE),   0);
      noise(-1);
      rsp_ready = (d == rdly);
    end
    @(posedge PCLK);
    #1;
    rsp_ready = 1'b0;
    @(negedge PCLK);
    check_val("post_rsp_valid", 64'(rsp_valid), 0);
    check_val("post_cmd_ready", 64'(cmd_ready), 1);
  endtask

  task automatic reset_mid_access();
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_2008;
    cmd_wdata = 32'hCAFE_F00D; cmd_strb = 4'h3;
    PREADY = '0;
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    PREADY = '0;
    @(negedge PCLK);
    check_val("rst_pre_penable", 64'(PENABLE), 1);
    check_val("rst_pre_psel",    64'(PSEL),    64'h4);
    #2;
    PRESET = 1'b1;
    PREADY = '1;
    #1;
    check_all_zero("rst_async");
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    check_val("rst_rel_cmd_ready", 64'(cmd_ready), 1);
    for (int c = 0; c < 3; c++) begin
      check_val("rst_rel_rsp_valid", 64'(rsp_valid), 0);
      check_val("rst_rel_psel",      64'(PSEL),      0);
      @(negedge PCLK);
    end
    PREADY = '0;
  endtask

  initial begin
    PRESET    = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    rsp_ready = 1'b0;
    PREADY = '0; PRDATA = '0; PSLVERR = '0;
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;

    txn(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h5555_AAAA, 0);
    txn(1'b0, 32'h0000_3010, 32'h0BAD_0BAD, 4'hF, 3, 1'b0, 32'h1234_5678, 0);
    txn(1'b1, 32'h0001_0000, 32'h1111_2222, 4'hF, 0, 1'b0, 32'h0, 1);
    txn(1'b0, 32'h8000_0000, 32'h0,         4'h0, 0, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h0000_0020, 32'h0,         4'hA, 0, 1'b1, 32'hAAAA_5555, 5);
    reset_mid_access();
    txn(1'b0, 32'h0000_2004, 32'h0,         4'h0, 1, 1'b0, 32'h0F0F_0F0F, 0);
`ifdef APB_TIMEOUT_EN
    txn(1'b0, 32'h0000_2000, 32'h0,         4'h0, TO_CYC,     1'b0, 32'h7777_7777, 0);
    txn(1'b0, 32'h0000_2004, 32'h0,         4'h0, TO_CYC - 1, 1'b0, 32'h8888_8888, 0);
`else
    txn(1'b0, 32'h0000_2000, 32'h0,         4'h0, 20, 1'b0, 32'h7777_7777, 0);
`endif

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << SLV_AW) | ($urandom & 32'h0000_0FFC);
      if ($urandom_range(0, 4) == 0) a = a | (32'h1 << $urandom_range(14, 31));
      txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 4),
          ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
